id_ex_stage: RTL and testbench

ID/EX pipeline register for the 5-stage MIPS-style pipeline. It sits directly downstream of the decode stage (register file read, control decode, 16→32-bit sign extension) and captures the decoded operands, sign-extended immediate and control bits for the execute stage. It also detects load-use hazards, inserts one-cycle bubbles, and honours branch/jump flushes. A valid/ready handshake runs on both sides.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/id_ex_stage_load_use_detect.sv | 23 ++
 rtl/id_ex_stage.sv | 141 ++++++++++++++
 tb/tb_id_ex_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: packed control bus layout used by decode, ID/EX and execute.
// Layout (MSB..LSB): {alu_op[3:0], alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write}.
package pipe_pkg;

    localparam int CTRL_W          = 10;
    localparam int CTRL_ALU_OP_LSB = 6;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_REG_DST    = 4;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_REG_WRITE  = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard check between the load in ID/EX and the
// instruction currently presented by decode.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_ex_valid,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_dst,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    output logic                  o_hazard
);

    logic w_dst_nonzero;
    logic w_src_match;

    // $0 is hardwired to zero, so a load into it can never feed a consumer.
    assign w_dst_nonzero = (i_ex_dst != '0);
    assign w_src_match   = (i_ex_dst == i_id_rs) || (i_ex_dst == i_id_rt);
    assign o_hazard      = i_ex_valid & i_ex_mem_read & w_dst_nonzero & i_id_valid & w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and valid/ready handshake.
// Optional build macro ID_EX_PERF_CNT_EN adds perf_bubbles / perf_flushes counter ports.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = pipe_pkg::CTRL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm_ext,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic                  hazard_stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           perf_bubbles,
    output logic [31:0]           perf_flushes
`endif
);

    logic                  r_valid;
    logic [DATA_W-1:0]     r_pc;
    logic [DATA_W-1:0]     r_rs_data;
    logic [DATA_W-1:0]     r_rt_data;
    logic [DATA_W-1:0]     r_imm;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_dst;
    logic [CTRL_W-1:0]     r_ctrl;

    logic                  w_advance;
    logic                  w_hazard;
    logic                  w_capture;
    logic [REG_ADDR_W-1:0] w_dst_sel;

    assign w_advance = ex_ready | ~r_valid;
    assign w_capture = id_valid & ~flush & ~w_hazard;
    assign w_dst_sel = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl[CTRL_MEM_READ]),
        .i_ex_dst      (r_dst),
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .o_hazard      (w_hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dst     <= '0;
            r_ctrl    <= CTRL_W'(CTRL_BUBBLE);
        end else if (w_advance) begin
            if (w_capture) begin
                r_valid   <= 1'b1;
                r_pc      <= id_pc;
                r_rs_data <= id_rs_data;
                r_rt_data <= id_rt_data;
                r_imm     <= id_imm_ext;
                r_rs      <= id_rs;
                r_rt      <= id_rt;
                r_dst     <= w_dst_sel;
                r_ctrl    <= id_ctrl;
            end else begin
                // Flush, load-use or idle: a fully zeroed bubble so no write strobe leaks.
                r_valid   <= 1'b0;
                r_pc      <= '0;
                r_rs_data <= '0;
                r_rt_data <= '0;
                r_imm     <= '0;
                r_rs      <= '0;
                r_rt      <= '0;
                r_dst     <= '0;
                r_ctrl    <= CTRL_W'(CTRL_BUBBLE);
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_perf_bubbles;
    logic [31:0] r_perf_flushes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_bubbles <= '0;
            r_perf_flushes <= '0;
        end else if (w_advance) begin
            if (w_hazard && !flush) r_perf_bubbles <= r_perf_bubbles + 32'd1;
            if (flush)              r_perf_flushes <= r_perf_flushes + 32'd1;
        end
    end

    assign perf_bubbles = r_perf_bubbles;
    assign perf_flushes = r_perf_flushes;
`endif

    // Reset forces id_ready low even though an empty register would otherwise advance.
    assign id_ready     = rst_n & w_advance & (~w_hazard | flush);
    assign hazard_stall = w_hazard & ~flush;

    assign ex_valid   = r_valid;
    assign ex_pc      = r_pc;
    assign ex_rs_data = r_rs_data;
    assign ex_rt_data = r_rt_data;
    assign ex_imm     = r_imm;
    assign ex_rs      = r_rs;
    assign ex_rt      = r_rt;
    assign ex_dst     = r_dst;
    assign ex_ctrl    = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, streaming, load-use stall,
// backpressure, flush priority and $0 loads. Perf counters checked when ID_EX_PERF_CNT_EN is set.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm_ext;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [9:0]  id_ctrl;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [9:0]  ex_ctrl;
    logic        hazard_stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubbles, perf_flushes;
    logic [31:0] snap_bubbles, snap_flushes;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // ctrl encodings {alu_op[3:0], alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write}
    localparam logic [9:0] C_ADDI = 10'b0010_1_0_0_0_0_1;  // 0x0A1
    localparam logic [9:0] C_ADD  = 10'b0010_0_1_0_0_0_1;  // 0x091
    localparam logic [9:0] C_SUB  = 10'b0110_0_1_0_0_0_1;  // 0x191
    localparam logic [9:0] C_LW   = 10'b0010_1_0_1_0_1_1;  // 0x0AB
    localparam logic [9:0] C_SW   = 10'b0010_1_0_0_1_0_0;  // 0x0A4

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm_ext   (id_imm_ext),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_ctrl      (id_ctrl),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_imm       (ex_imm),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_dst       (ex_dst),
        .ex_ctrl      (ex_ctrl),
        .hazard_stall (hazard_stall)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .perf_bubbles (perf_bubbles),
        .perf_flushes (perf_flushes)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [9:0] ctrl);
        id_valid = v; id_pc = pc; id_rs_data = rsd; id_rt_data = rtd; id_imm_ext = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc,
                            input logic [4:0] dst, input logic [9:0] ctrl);
        chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, v});
        chk({tag, ".pc"},    ex_pc, pc);
        chk({tag, ".dst"},   {27'd0, ex_dst}, {27'd0, dst});
        chk({tag, ".ctrl"},  {22'd0, ex_ctrl}, {22'd0, ctrl});
        $display("txn %s: valid=%0d pc=%h dst=%0d ctrl=%h", tag, ex_valid, ex_pc, ex_dst, ex_ctrl);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        idle();
        tick(); tick();
        chk("por.valid", {31'd0, ex_valid}, 32'd0);
        chk("por.id_ready", {31'd0, id_ready}, 32'd0);
        rst_n = 1'b1;

        // Pre-fill, then assert reset asynchronously mid-cycle
        drive(1'b1, 32'h0000_0004, 32'h0, 32'h11, 32'h0000_0010, 5'd0, 5'd1, 5'd0, C_ADDI);
        tick();
        chk_slot("prefill", 1'b1, 32'h0000_0004, 5'd1, C_ADDI);
        rst_n = 1'b0;
        #1;
        chk_slot("rst_async", 1'b0, 32'h0, 5'd0, 10'h0);
        chk("rst_async.imm", ex_imm, 32'h0);
        chk("rst_async.id_ready", {31'd0, id_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold.valid", {31'd0, ex_valid}, 32'd0);
            chk("rst_hold.id_ready", {31'd0, id_ready}, 32'd0);
        end
        rst_n = 1'b1;

        // Stream: addi $1,$0,-4 ; add $3,$4,$5 ; sub $7,$8,$9 ; sw $10,8($11)
        drive(1'b1, 32'h0000_0100, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd0, 5'd1, 5'd9, C_ADDI);
        #1;
        chk("addi.id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk_slot("addi", 1'b1, 32'h0000_0100, 5'd1, C_ADDI);
        chk("addi.imm", ex_imm, 32'hFFFF_FFFC);
        chk("addi.rt", {27'd0, ex_rt}, 32'd1);
        drive(1'b1, 32'h0000_0104, 32'hAAAA_0004, 32'hBBBB_0005, 32'h0000_1820, 5'd4, 5'd5, 5'd3, C_ADD);
        tick();
        chk_slot("add", 1'b1, 32'h0000_0104, 5'd3, C_ADD);
        chk("add.rs_data", ex_rs_data, 32'hAAAA_0004);
        chk("add.rt_data", ex_rt_data, 32'hBBBB_0005);
        chk("add.rs", {27'd0, ex_rs}, 32'd4);
        drive(1'b1, 32'h0000_0108, 32'h0000_0008, 32'h0000_0009, 32'h0000_3822, 5'd8, 5'd9, 5'd7, C_SUB);
        tick();
        chk_slot("sub", 1'b1, 32'h0000_0108, 5'd7, C_SUB);
        chk("sub.imm", ex_imm, 32'h0000_3822);
        drive(1'b1, 32'h0000_010C, 32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0008, 5'd11, 5'd10, 5'd0, C_SW);
        tick();
        chk_slot("sw", 1'b1, 32'h0000_010C, 5'd10, C_SW);
        chk("sw.rt_data", ex_rt_data, 32'hCAFE_F00D);

        // lw $5,0($2) then add $6,$5,$2 : one bubble
        drive(1'b1, 32'h0000_0200, 32'h0000_2000, 32'h0, 32'h0, 5'd2, 5'd5, 5'd0, C_LW);
        tick();
        chk_slot("lw1", 1'b1, 32'h0000_0200, 5'd5, C_LW);
        drive(1'b1, 32'h0000_0204, 32'h0, 32'h2, 32'h0, 5'd5, 5'd2, 5'd6, C_ADD);
        #1;
        chk("lu.hazard_stall", {31'd0, hazard_stall}, 32'd1);
        chk("lu.id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        chk_slot("lu.bubble", 1'b0, 32'h0, 5'd0, 10'h0);
        chk("lu.after.hazard_stall", {31'd0, hazard_stall}, 32'd0);
        chk("lu.after.id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk_slot("lu.add", 1'b1, 32'h0000_0204, 5'd6, C_ADD);

        // Same pair with ex_ready low for two cycles
        drive(1'b1, 32'h0000_0300, 32'h0, 32'h0, 32'h0, 5'd2, 5'd5, 5'd0, C_LW);
        tick();
        ex_ready = 1'b0;
        drive(1'b1, 32'h0000_0304, 32'h0, 32'h2, 32'h0, 5'd5, 5'd2, 5'd6, C_ADD);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp.id_ready", {31'd0, id_ready}, 32'd0);
            chk("bp.hazard_stall", {31'd0, hazard_stall}, 32'd1);
            tick();
            chk_slot("bp.hold", 1'b1, 32'h0000_0300, 5'd5, C_LW);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp.rise.id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        chk_slot("bp.bubble", 1'b0, 32'h0, 5'd0, 10'h0);
        tick();
        chk_slot("bp.add", 1'b1, 32'h0000_0304, 5'd6, C_ADD);

        // flush + load-use on the same cycle: flush wins
        drive(1'b1, 32'h0000_0400, 32'h0, 32'h0, 32'h0, 5'd2, 5'd5, 5'd0, C_LW);
        tick();
        drive(1'b1, 32'h0000_0404, 32'h0, 32'h2, 32'h0, 5'd5, 5'd2, 5'd6, C_ADD);
        flush = 1'b1;
`ifdef ID_EX_PERF_CNT_EN
        snap_bubbles = perf_bubbles;
        snap_flushes = perf_flushes;
        chk("perf.bubbles_before", perf_bubbles, 32'd2);
`endif
        #1;
        chk("fl.hazard_stall", {31'd0, hazard_stall}, 32'd0);
        chk("fl.id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk_slot("fl.bubble", 1'b0, 32'h0, 5'd0, 10'h0);
`ifdef ID_EX_PERF_CNT_EN
        chk("perf.flushes", perf_flushes, snap_flushes + 32'd1);
        chk("perf.bubbles", perf_bubbles, snap_bubbles);
`endif
        flush = 1'b0;

        // flush while the register is held: no effect
        drive(1'b1, 32'h0000_0500, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, C_ADD);
        tick();
        ex_ready = 1'b0;
        flush = 1'b1;
        idle();
        tick();
        chk_slot("fl_held", 1'b1, 32'h0000_0500, 5'd3, C_ADD);
        flush = 1'b0;
        ex_ready = 1'b1;

        // lw $0 followed by a consumer of $0: no stall
        drive(1'b1, 32'h0000_0600, 32'h0, 32'h0, 32'h0, 5'd2, 5'd0, 5'd0, C_LW);
        tick();
        chk_slot("lw0", 1'b1, 32'h0000_0600, 5'd0, C_LW);
        drive(1'b1, 32'h0000_0604, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd6, C_ADD);
        #1;
        chk("lw0.hazard_stall", {31'd0, hazard_stall}, 32'd0);
        chk("lw0.id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk_slot("lw0.add", 1'b1, 32'h0000_0604, 5'd6, C_ADD);

        // idle cycle drains to a bubble
        idle();
        tick();
        chk_slot("drain", 1'b0, 32'h0, 5'd0, 10'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule
